regfile_self_checker: RTL and testbench

- Synthesizable on-chip successor to the simulation-only processor test harness.
- Lets the processor run for a programmed number of cycles while counting register writes.
- Then hijacks the regfile read port A, sweeps every register and compares each value against an expected-value ROM.
- Reports pass/fail, error count and first mismatch; sits beside processor and regfile, muxing the rs1 read address.

---
 rtl/regfile_self_checker.sv | 184 ++++++++++++++++++
 tb/tb_regfile_self_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_self_checker.sv
// regfile_self_checker
//   On-chip run-and-verify harness placed beside a processor and its regfile.
//   The processor runs for a programmed number of cycles while register writes
//   are counted. Then read port A is taken over, every register is swept and
//   compared against an expected-value ROM, and a verdict is held until the
//   next start.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, num_cycles     start pulse (IDLE/DONE only) and run length
//   rwe, rd               processor regfile write enable / index (counted)
//   cpu_rs1, rs1_out      processor read-A index in, muxed index to regfile
//   reg_data              regfile read-A data (combinational read)
//   exp_addr, exp_data    expected-value ROM address / data (1-cycle latency)
//   cpu_hold, test_mode   processor hold, sweep in progress
//   done, pass            verdict flags
//   error_count, write_count, first_fail_reg/exp/act   result registers
module regfile_self_checker #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_BITS  = 5,
   parameter int CYCLE_BITS = 16,
   parameter int SKIP_R0    = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CYCLE_BITS-1:0] num_cycles,
   input  logic                  rwe,
   input  logic [ADDR_BITS-1:0]  rd,
   input  logic [ADDR_BITS-1:0]  cpu_rs1,
   output logic [ADDR_BITS-1:0]  rs1_out,
   input  logic [DATA_WIDTH-1:0] reg_data,
   output logic [ADDR_BITS-1:0]  exp_addr,
   input  logic [DATA_WIDTH-1:0] exp_data,
   output logic                  cpu_hold,
   output logic                  test_mode,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_BITS:0]    error_count,
   output logic [CYCLE_BITS-1:0] write_count,
   output logic [ADDR_BITS-1:0]  first_fail_reg,
   output logic [DATA_WIDTH-1:0] first_fail_exp,
   output logic [DATA_WIDTH-1:0] first_fail_act
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

   state_t                r_state;
   logic [CYCLE_BITS-1:0] r_cyc_cnt;
   logic [CYCLE_BITS-1:0] r_ncyc;
   logic [CYCLE_BITS-1:0] r_write_count;
   logic [ADDR_BITS-1:0]  r_test_reg;
   logic                  r_sweep;
   logic                  r_p_valid;
   logic [ADDR_BITS-1:0]  r_p_idx;
   logic [DATA_WIDTH-1:0] r_p_val;
   logic [ADDR_BITS:0]    r_error_count;
   logic [ADDR_BITS-1:0]  r_ff_reg;
   logic [DATA_WIDTH-1:0] r_ff_exp;
   logic [DATA_WIDTH-1:0] r_ff_act;
   logic                  r_test_mode;
   logic                  r_cpu_hold;
   logic                  r_done;
   logic                  r_pass;

   logic                  w_run_last;
   logic                  w_sweep_last;
   logic                  w_cmp_en;
   logic                  w_mismatch;
   logic [ADDR_BITS:0]    w_err_next;
   logic                  w_pipe_last;
   logic                  w_wr;

   // A zero run length still spends one cycle in RUN.
   assign w_run_last   = (r_ncyc == '0) || (r_cyc_cnt == r_ncyc - CYCLE_BITS'(1));
   assign w_sweep_last = (r_test_reg == ADDR_BITS'(NUM_REGS - 1));
   // Pipe holds the regfile value read last cycle; the ROM word for the same
   // index arrives now, so the comparison happens one cycle behind the sweep.
   assign w_cmp_en     = r_p_valid && !((SKIP_R0 != 0) && (r_p_idx == '0));
   assign w_mismatch   = w_cmp_en && (r_p_val != exp_data);
   assign w_err_next   = r_error_count + (ADDR_BITS + 1)'(w_mismatch);
   assign w_pipe_last  = r_p_valid && (r_p_idx == ADDR_BITS'(NUM_REGS - 1));
   assign w_wr         = rwe && (rd != '0);

   assign rs1_out        = r_test_mode ? r_test_reg : cpu_rs1;
   assign exp_addr       = r_test_reg;
   assign cpu_hold       = r_cpu_hold;
   assign test_mode      = r_test_mode;
   assign done           = r_done;
   assign pass           = r_pass;
   assign error_count    = r_error_count;
   assign write_count    = r_write_count;
   assign first_fail_reg = r_ff_reg;
   assign first_fail_exp = r_ff_exp;
   assign first_fail_act = r_ff_act;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cyc_cnt     <= '0;
         r_ncyc        <= '0;
         r_write_count <= '0;
         r_test_reg    <= '0;
         r_sweep       <= 1'b0;
         r_p_valid     <= 1'b0;
         r_p_idx       <= '0;
         r_p_val       <= '0;
         r_error_count <= '0;
         r_ff_reg      <= '0;
         r_ff_exp      <= '0;
         r_ff_act      <= '0;
         r_test_mode   <= 1'b0;
         r_cpu_hold    <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state       <= S_RUN;
                  r_cyc_cnt     <= '0;
                  r_ncyc        <= num_cycles;
                  r_write_count <= '0;
                  r_error_count <= '0;
                  r_ff_reg      <= '0;
                  r_ff_exp      <= '0;
                  r_ff_act      <= '0;
                  r_p_valid     <= 1'b0;
                  r_test_mode   <= 1'b0;
                  r_cpu_hold    <= 1'b0;
                  r_done        <= 1'b0;
                  r_pass        <= 1'b0;
               end
            end

            S_RUN: begin
               r_cyc_cnt <= r_cyc_cnt + CYCLE_BITS'(1);
               if (w_wr && (r_write_count != '1))
                  r_write_count <= r_write_count + CYCLE_BITS'(1);
               if (w_run_last) begin
                  r_state     <= S_CHECK;
                  r_test_mode <= 1'b1;
                  r_cpu_hold  <= 1'b1;
                  r_test_reg  <= '0;
                  r_sweep     <= 1'b1;
                  r_p_valid   <= 1'b0;
               end
            end

            S_CHECK: begin
               if (r_sweep) begin
                  r_p_idx   <= r_test_reg;
                  r_p_val   <= reg_data;
                  r_p_valid <= 1'b1;
                  if (w_sweep_last)
                     r_sweep <= 1'b0;
                  else
                     r_test_reg <= r_test_reg + ADDR_BITS'(1);
               end else begin
                  r_p_valid <= 1'b0;
               end

               r_error_count <= w_err_next;
               if (w_mismatch && (r_error_count == '0)) begin
                  r_ff_reg <= r_p_idx;
                  r_ff_exp <= exp_data;
                  r_ff_act <= r_p_val;
               end

               if (w_pipe_last) begin
                  r_state     <= S_DONE;
                  r_test_mode <= 1'b0;
                  r_done      <= 1'b1;
                  r_pass      <= (w_err_next == '0);
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_self_checker.sv
// Bench for regfile_self_checker: two instances (SKIP_R0=1 and SKIP_R0=0)
// share stimulus, a regfile array and a ROM array. Expected results are
// computed directly from the arrays and the recorded write stimulus.
module tb_regfile_self_checker;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AB = 5;
   localparam int CB = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [CB-1:0] num_cycles;
   logic          rwe;
   logic [AB-1:0] rd;
   logic [AB-1:0] cpu_rs1;

   logic [DW-1:0] rf  [NR];
   logic [DW-1:0] rom [NR];

   // instance with SKIP_R0=1 (suffix _s) and SKIP_R0=0 (suffix _n)
   logic [AB-1:0] rs1_s, rs1_n, ea_s, ea_n;
   logic [DW-1:0] rdat_s, rdat_n, edat_s, edat_n;
   logic          hold_s, hold_n, tm_s, tm_n, done_s, done_n, pass_s, pass_n;
   logic [AB:0]   ec_s, ec_n;
   logic [CB-1:0] wc_s, wc_n;
   logic [AB-1:0] ffr_s, ffr_n;
   logic [DW-1:0] ffe_s, ffe_n, ffa_s, ffa_n;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clock = ~clock;

   assign rdat_s = rf[rs1_s];
   assign rdat_n = rf[rs1_n];
   always @(posedge clock) begin
      edat_s <= rom[ea_s];
      edat_n <= rom[ea_n];
   end

   regfile_self_checker #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_BITS(AB),
                          .CYCLE_BITS(CB), .SKIP_R0(1)) u_dut_s (
      .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
      .rwe(rwe), .rd(rd), .cpu_rs1(cpu_rs1), .rs1_out(rs1_s),
      .reg_data(rdat_s), .exp_addr(ea_s), .exp_data(edat_s),
      .cpu_hold(hold_s), .test_mode(tm_s), .done(done_s), .pass(pass_s),
      .error_count(ec_s), .write_count(wc_s), .first_fail_reg(ffr_s),
      .first_fail_exp(ffe_s), .first_fail_act(ffa_s));

   regfile_self_checker #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_BITS(AB),
                          .CYCLE_BITS(CB), .SKIP_R0(0)) u_dut_n (
      .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
      .rwe(rwe), .rd(rd), .cpu_rs1(cpu_rs1), .rs1_out(rs1_n),
      .reg_data(rdat_n), .exp_addr(ea_n), .exp_data(edat_n),
      .cpu_hold(hold_n), .test_mode(tm_n), .done(done_n), .pass(pass_n),
      .error_count(ec_n), .write_count(wc_n), .first_fail_reg(ffr_n),
      .first_fail_exp(ffe_n), .first_fail_act(ffa_n));

   task automatic chk(input string tag, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // reference: mismatch count and first mismatching index (-1 if none)
   function automatic int model_errors(input bit skip);
      int n = 0;
      for (int i = 0; i < NR; i++)
         if (!(skip && i == 0) && rf[i] != rom[i]) n++;
      return n;
   endfunction

   function automatic int model_first(input bit skip);
      for (int i = 0; i < NR; i++)
         if (!(skip && i == 0) && rf[i] != rom[i]) return i;
      return -1;
   endfunction

   task automatic fill_equal();
      for (int i = 0; i < NR; i++) begin
         rom[i] = $urandom;
         rf[i]  = rom[i];
      end
   endtask

   task automatic check_idle_state(input string pfx);
      chk({pfx, "_tm_s"},   tm_s, 0);      chk({pfx, "_tm_n"},   tm_n, 0);
      chk({pfx, "_hold_s"}, hold_s, 0);    chk({pfx, "_hold_n"}, hold_n, 0);
      chk({pfx, "_done_s"}, done_s, 0);    chk({pfx, "_pass_s"}, pass_s, 0);
      chk({pfx, "_ec_s"},   ec_s, 0);      chk({pfx, "_ec_n"},   ec_n, 0);
      chk({pfx, "_wc_s"},   wc_s, 0);      chk({pfx, "_ea_s"},   ea_s, 0);
      chk({pfx, "_ffr_n"},  ffr_n, 0);     chk({pfx, "_ffe_n"},  ffe_n, 0);
      chk({pfx, "_ffa_n"},  ffa_n, 0);
      chk({pfx, "_rs1_s"},  rs1_s, cpu_rs1);
   endtask

   task automatic check_final(input int wc);
      for (int s = 0; s < 2; s++) begin
         int    e   = model_errors(s == 1);
         int    f   = model_first(s == 1);
         string sfx = (s == 1) ? "_s" : "_n";
         longint ffr = (f < 0) ? 0 : f;
         longint ffe = (f < 0) ? 0 : rom[f];
         longint ffa = (f < 0) ? 0 : rf[f];
         chk({"done", sfx}, (s == 1) ? done_s : done_n, 1);
         chk({"pass", sfx}, (s == 1) ? pass_s : pass_n, (e == 0) ? 1 : 0);
         chk({"ec", sfx},   (s == 1) ? ec_s : ec_n, e);
         chk({"wc", sfx},   (s == 1) ? wc_s : wc_n, wc);
         chk({"ffr", sfx},  (s == 1) ? ffr_s : ffr_n, ffr);
         chk({"ffe", sfx},  (s == 1) ? ffe_s : ffe_n, ffe);
         chk({"ffa", sfx},  (s == 1) ? ffa_s : ffa_n, ffa);
         chk({"tm_done", sfx},   (s == 1) ? tm_s : tm_n, 0);
         chk({"hold_done", sfx}, (s == 1) ? hold_s : hold_n, 1);
         chk({"rs1_done", sfx},  (s == 1) ? rs1_s : rs1_n, cpu_rs1);
      end
   endtask

   // mode 0: random writes; 1: rwe=1 rd=3 always; 2: rd=0 on 5 random cycles, else rd=7
   // abort_at >= 0: assert reset once the sweep index reaches abort_at
   task automatic do_run(input int n, input int mode, input int abort_at);
      int         r  = (n == 0) ? 1 : n;
      int         wc = 0;
      int         zc = 0;
      int         p;
      bit [63:0]  zmask = '0;
      if (mode == 2)
         while (zc < 5) begin
            p = $urandom_range(0, r - 1);
            if (!zmask[p]) begin zmask[p] = 1'b1; zc++; end
         end
      @(negedge clock);
      start = 1'b1; num_cycles = CB'(n); rwe = 1'b0;
      @(negedge clock);
      start = 1'b0;
      chk("clr_ec_s", ec_s, 0);     chk("clr_ec_n", ec_n, 0);
      chk("clr_done", done_s, 0);   chk("clr_pass", pass_n, 0);
      chk("clr_hold", hold_s, 0);   chk("clr_tm", tm_n, 0);
      chk("clr_ffr", ffr_n, 0);     chk("clr_wc", wc_s, 0);
      for (int k = 1; k <= r + 33; k++) begin
         cpu_rs1 = AB'($urandom);
         if (k <= r) begin
            case (mode)
               1:       begin rwe = 1'b1; rd = 5'd3; end
               2:       begin rwe = 1'b1; rd = zmask[k-1] ? 5'd0 : 5'd7; end
               default: begin rwe = 1'($urandom_range(0, 1)); rd = AB'($urandom); end
            endcase
            if (rwe && rd != 0) wc++;
         end else begin
            rwe = 1'($urandom_range(0, 1));
            rd  = AB'($urandom);
         end
         start      = (k < r + 33) ? ($urandom_range(0, 3) == 0) : 1'b0;
         num_cycles = CB'($urandom);
         @(negedge clock);
         if (k == r) begin
            chk("tm_check_s", tm_s, 1);     chk("tm_check_n", tm_n, 1);
            chk("hold_check", hold_s, 1);   chk("wc_run", wc_s, wc);
            chk("rs1_sweep0", rs1_n, 0);
         end
         if (abort_at >= 0 && k == r + abort_at) begin
            chk("rs1_abort", rs1_s, abort_at);
            chk("ea_abort", ea_n, abort_at);
            reset = 1'b1; start = 1'b0;
            @(negedge clock);
            check_idle_state("abort");
            reset = 1'b0;
            return;
         end
         if (k == r + 32) begin
            chk("done_early_s", done_s, 0);
            chk("done_early_n", done_n, 0);
         end
      end
      check_final(wc);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; num_cycles = '0; rwe = 1'b0; rd = '0;
      cpu_rs1 = 5'd17;
      fill_equal();
      repeat (3) @(negedge clock);
      check_idle_state("reset");
      reset = 1'b0;

      // clean run, constant writes to r3
      do_run(10, 1, -1);
      // half the writes target r0
      do_run(10, 2, -1);

      // two mismatches: r5 (42 vs 41) and r9
      rf[5] = 32'd42; rom[5] = 32'd41;
      rf[9] = rom[9] ^ 32'h0000_0100;
      do_run(10, 0, -1);

      // only r0 differs: SKIP_R0 instance passes, the other flags r0
      fill_equal();
      rf[0] = rom[0] + 32'd1;
      do_run(7, 0, -1);

      // reset in the middle of the sweep
      do_run(10, 0, 12);

      // leave a failing result in DONE, then restart with zero run length
      rf[20] = ~rom[20];
      do_run(5, 0, -1);
      fill_equal();
      do_run(0, 0, -1);

      // randomized runs with random mismatch sets
      for (int t = 0; t < 8; t++) begin
         fill_equal();
         for (int m = $urandom_range(0, 3); m > 0; m--) begin
            int idx = $urandom_range(0, NR - 1);
            rf[idx] = rf[idx] ^ (32'd1 << $urandom_range(0, 31));
         end
         do_run($urandom_range(0, 20), 0, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
